// File: rtl/hzdm_pkg.sv
// rtl/hzdm_pkg.sv - shared register-file geometry and hazard-window defaults
package hzdm_pkg;

    localparam int REG_COUNT        = 32;
    localparam int REG_ADDR_W       = 5;
    localparam int MAX_INFLIGHT_DEF = 3;

endpackage

// File: rtl/hzdm_counter.sv
// rtl/hzdm_counter.sv - up/down counter that holds when inc and dec coincide
module hzdm_counter #(
    parameter int CW = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          zero_o
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_o <= '0;
        end else if (inc_i && !dec_i) begin
            count_o <= count_o + CW'(1);
        end else if (dec_i && !inc_i) begin
            count_o <= count_o - CW'(1);
        end
    end

    assign zero_o = (count_o == '0);

endmodule

// File: rtl/hzdm.sv
// rtl/hzdm.sv - register-hazard scoreboard and issue controller between decode and execute
module hzdm
    import hzdm_pkg::*;
#(
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  dec_valid_i,
    input  logic                                  dec_use1_i,
    input  logic                                  dec_use2_i,
    input  logic [REG_ADDR_W-1:0]                 dec_raddr1_i,
    input  logic [REG_ADDR_W-1:0]                 dec_raddr2_i,
    input  logic                                  dec_write_i,
    input  logic [REG_ADDR_W-1:0]                 dec_waddr_i,
    input  logic                                  exm_ready_i,
    input  logic                                  flush_i,
    input  logic                                  retire_i,
    input  logic [REG_ADDR_W-1:0]                 retire_addr_i,
    output logic                                  stall_o,
    output logic                                  issue_o,
    output logic [REG_COUNT-1:0]                  busy_o,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight_o,
    output logic                                  error_o
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic [CW-1:0]        reg_cnt [REG_COUNT];
    logic [REG_COUNT-1:0] reg_zero;
    logic [CW-1:0]        inflight;
    logic                 inflight_zero_unused;
    logic                 hazard;
    logic                 full;
    logic                 inc;
    logic                 dec;
    logic                 bad_retire;
    logic                 error_q;

    // x0 is hardwired: never counted, never busy.
    assign reg_cnt[0]  = '0;
    assign reg_zero[0] = 1'b1;
    assign busy_o      = ~reg_zero;

    assign hazard = (dec_use1_i && (dec_raddr1_i != '0) && busy_o[dec_raddr1_i]) ||
                    (dec_use2_i && (dec_raddr2_i != '0) && busy_o[dec_raddr2_i]);
    assign full   = dec_write_i && (dec_waddr_i != '0) && (inflight == CW'(MAX_INFLIGHT));

    assign stall_o = dec_valid_i && (hazard || full || flush_i);
    assign issue_o = dec_valid_i && exm_ready_i && !stall_o;

    assign inc        = issue_o && dec_write_i && (dec_waddr_i != '0);
    assign dec        = retire_i && (retire_addr_i != '0) && (reg_cnt[retire_addr_i] != '0);
    assign bad_retire = retire_i && (retire_addr_i != '0) && (reg_cnt[retire_addr_i] == '0);

    for (genvar n = 1; n < REG_COUNT; n++) begin : g_reg
        hzdm_counter #(.CW(CW)) u_cnt (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .inc_i   (inc && (dec_waddr_i == REG_ADDR_W'(n))),
            .dec_i   (dec && (retire_addr_i == REG_ADDR_W'(n))),
            .count_o (reg_cnt[n]),
            .zero_o  (reg_zero[n])
        );
    end

    hzdm_counter #(.CW(CW)) u_inflight (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (inc),
        .dec_i   (dec),
        .count_o (inflight),
        .zero_o  (inflight_zero_unused)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            error_q <= 1'b0;
        end else if (bad_retire) begin
            error_q <= 1'b1;
        end
    end

    assign inflight_o = inflight;
    assign error_o    = error_q;

endmodule

// File: tb/tb_hzdm.sv
// tb/tb_hzdm.sv - directed self-checking bench for the hazard scoreboard
module tb_hzdm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dec_valid, dec_use1, dec_use2, dec_write, exm_ready, flush, retire;
    logic [4:0]  dec_raddr1, dec_raddr2, dec_waddr, retire_addr;
    logic        stall, issue, error;
    logic [31:0] busy;
    logic [1:0]  inflight;

    int tests  = 0;
    int failed = 0;

    hzdm #(.MAX_INFLIGHT(3)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .dec_valid_i   (dec_valid),
        .dec_use1_i    (dec_use1),
        .dec_use2_i    (dec_use2),
        .dec_raddr1_i  (dec_raddr1),
        .dec_raddr2_i  (dec_raddr2),
        .dec_write_i   (dec_write),
        .dec_waddr_i   (dec_waddr),
        .exm_ready_i   (exm_ready),
        .flush_i       (flush),
        .retire_i      (retire),
        .retire_addr_i (retire_addr),
        .stall_o       (stall),
        .issue_o       (issue),
        .busy_o        (busy),
        .inflight_o    (inflight),
        .error_o       (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic u1, input logic [4:0] r1,
                         input logic u2, input logic [4:0] r2,
                         input logic wr, input logic [4:0] wa, input logic rdy,
                         input logic fl, input logic rt, input logic [4:0] ra);
        dec_valid = v;  dec_use1 = u1; dec_raddr1 = r1;
        dec_use2 = u2;  dec_raddr2 = r2;
        dec_write = wr; dec_waddr = wa; exm_ready = rdy;
        flush = fl;     retire = rt;    retire_addr = ra;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        #12;
        chk("reset_busy", busy, 32'h0);
        chk("reset_inflight", {30'd0, inflight}, 32'd0);
        chk("reset_error", {31'd0, error}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // RAW: write x3, then a reader of x3 stalls until x3 retires
        drive(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
        chk("raw_first_issue", {31'd0, issue}, 32'd1);
        tick();
        chk("raw_busy3", busy, 32'h8);
        chk("raw_inflight1", {30'd0, inflight}, 32'd1);
        drive(1, 1, 3, 0, 0, 1, 10, 1, 0, 1, 3);
        chk("raw_stall", {31'd0, stall}, 32'd1);
        chk("raw_no_issue", {31'd0, issue}, 32'd0);
        tick();
        chk("raw_busy_clear", busy, 32'h0);
        drive(1, 1, 3, 0, 0, 1, 10, 1, 0, 0, 0);
        chk("raw_issue_after_retire", {31'd0, issue}, 32'd1);
        tick();
        chk("raw_busy10", busy, 32'h400);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10);
        tick();
        chk("raw_drain", {30'd0, inflight}, 32'd0);

        // Window full: three writers in flight block a fourth writer
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0);
        tick();
        chk("full_inflight3", {30'd0, inflight}, 32'd3);
        chk("full_busy", busy, 32'h16);
        drive(1, 0, 0, 0, 0, 1, 6, 1, 0, 1, 1);
        chk("full_stall", {31'd0, stall}, 32'd1);
        chk("full_no_issue", {31'd0, issue}, 32'd0);
        tick();
        chk("full_after_retire", {30'd0, inflight}, 32'd2);
        drive(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0);
        chk("full_issue_after_retire", {31'd0, issue}, 32'd1);
        tick();
        chk("full_busy6", busy, 32'h54);

        // Simultaneous issue and retire of x7 leaves its count at 1
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        tick();
        drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
        tick();
        chk("sim_pre_inflight", {30'd0, inflight}, 32'd2);
        drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 1, 7);
        chk("sim_issue", {31'd0, issue}, 32'd1);
        tick();
        chk("sim_busy7", busy, 32'hC0);
        chk("sim_inflight", {30'd0, inflight}, 32'd2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        tick();
        chk("sim_cnt7_was_1", busy, 32'h40);

        // x0 write, not-ready, flush and rs2 hazard
        drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        chk("x0_issue", {31'd0, issue}, 32'd1);
        tick();
        chk("x0_busy", busy, 32'h40);
        chk("x0_inflight", {30'd0, inflight}, 32'd1);
        drive(1, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0);
        chk("notready_issue", {31'd0, issue}, 32'd0);
        chk("notready_stall", {31'd0, stall}, 32'd0);
        drive(1, 1, 5, 0, 0, 1, 8, 1, 1, 0, 0);
        chk("flush_stall", {31'd0, stall}, 32'd1);
        chk("flush_issue", {31'd0, issue}, 32'd0);
        tick();
        chk("flush_busy", busy, 32'h40);
        drive(1, 0, 0, 1, 6, 1, 8, 1, 0, 0, 0);
        chk("rs2_stall", {31'd0, stall}, 32'd1);
        drive(1, 0, 0, 0, 6, 0, 0, 1, 0, 0, 0);
        chk("rs2_unused_issue", {31'd0, issue}, 32'd1);

        // Error: retire of an idle register
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        chk("err_before_edge", {31'd0, error}, 32'd0);
        tick();
        chk("err_set", {31'd0, error}, 32'd1);
        chk("err_busy", busy, 32'h40);
        chk("err_inflight", {30'd0, inflight}, 32'd1);
        idle();
        tick();
        chk("err_sticky", {31'd0, error}, 32'd1);

        // Mid-run async reset with cnt[5]=2
        drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
        tick();
        tick();
        chk("rst_pre_busy", busy, 32'h60);
        chk("rst_pre_inflight", {30'd0, inflight}, 32'd3);
        idle();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 32'h0);
        chk("rst_inflight", {30'd0, inflight}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        tick();
        rst = 1'b1;
        drive(1, 1, 5, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("rst_issue_rs5", {31'd0, issue}, 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/hzdm.md
# hzdm

Register-hazard scoreboard and issue controller for the five-stage pipeline. It sits between decm and exm and tracks every in-flight instruction that will write the register file. It stalls issue when a source operand has a pending write (no forwarding exists) or when the in-flight window is full. Retirements are reported from wbm on the regm write port.

## Interface
Parameters:
- MAX_INFLIGHT, 3: maximum issued-but-unretired writing instructions (exm + lsm + wbm).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-low.
- dec_valid_i  in  1  decm holds an instruction ready to issue.
- dec_use1_i / dec_use2_i  in  1  instruction reads rs1 / rs2.
- dec_raddr1_i / dec_raddr2_i  in  5  source register addresses.
- dec_write_i  in  1  instruction writes rd.
- dec_waddr_i  in  5  destination register address.
- exm_ready_i  in  1  exm can accept an instruction.
- flush_i  in  1  branch taken this cycle; suppress issue.
- retire_i  in  1  wbm writes regm this cycle.
- retire_addr_i  in  5  register written by wbm.
- stall_o  out  1  decm must hold.
- issue_o  out  1  instruction transfers decm→exm this cycle.
- busy_o  out  32  bit n set when register n has a pending write.
- inflight_o  out  $clog2(MAX_INFLIGHT+1)  total pending writes.
- error_o  out  1  sticky protocol error.

## Operation
- Per-register counter cnt[n], n=1..31, width CW=$clog2(MAX_INFLIGHT+1). x0 is never tracked; busy_o[0]=0 always.
- busy_o[n] = (cnt[n]!=0), taken from registered state only. A same-cycle retire does not clear busy for a read.
- hazard = (dec_use1_i & raddr1!=0 & busy[raddr1]) | (dec_use2_i & raddr2!=0 & busy[raddr2]).
- full = dec_write_i & waddr!=0 & (inflight==MAX_INFLIGHT).
- stall_o = dec_valid_i & (hazard | full | flush_i).
- issue_o = dec_valid_i & exm_ready_i & ~stall_o. Combinational from inputs and state.
- inc = issue_o & dec_write_i & dec_waddr_i!=0.
- dec = retire_i & retire_addr_i!=0 & cnt[retire_addr_i]!=0.
- Counter update per register:
  - inc only: +1.
  - dec only: −1.
  - both on the same register: unchanged.
- inflight follows the same rules: +inc −dec, unchanged when both occur.
- WAW is allowed: an issue to an already-busy rd increments its counter.
- Error: retire_i to a nonzero register whose counter is 0 sets error_o. error_o stays set until reset; no counter changes.
- Saturation cannot occur: full blocks the issue that would exceed MAX_INFLIGHT.
- flush_i only blocks the current cycle's issue. Already-issued instructions always retire through wbm, so counters are not cleared.

## Timing
- Reset (rst_i low, async): all cnt=0, inflight_o=0, busy_o=0, error_o=0. stall_o/issue_o follow their combinational equations with zero state.
- Counters and error_o update on the rising edge of clk_i.
- Issue→busy latency: busy_o[rd] rises the cycle after issue_o.
- Retire→busy clear: busy_o[rd] falls the cycle after retire_i. A dependent instruction issues at the earliest on that cycle.
- Reset asserted mid-operation clears all state immediately. The pipeline is reset simultaneously, so no stale retirements follow.
- Each cycle processes at most one issue and one retire.

## Structure
- Shared package holds REG_COUNT=32, REG_ADDR_W=5, and the MAX_INFLIGHT default, for use by decm/wbm/top.
- One natural sub-module: hzdm_counter (CW-bit up/down counter with inc/dec/both-hold and zero flag), instantiated 31× in a generate loop plus once for inflight.

## Test plan
- Reset:
  - Stimulus: hold rst_i low mid-run with cnt[5]=2, then release.
  - Response: busy_o=0, inflight_o=0, error_o=0 immediately.
  - Response: next dec_valid_i with rs1=5 issues (issue_o=1).
- RAW stall:
  - Stimulus: issue write x3. Next cycle, decode reads x3.
  - Response: stall_o=1, issue_o=0.
  - Stimulus: retire x3 at cycle T.
  - Response: issue_o=1 at T+1, busy_o[3]=0.
- Window full:
  - Stimulus: issue writes to x1, x2, x4 with no retire (inflight_o=3). Fourth instruction writes x6, reads nothing.
  - Response: stall_o=1.
  - Stimulus: one retire.
  - Response: next cycle issue_o=1.
- Simultaneous:
  - Stimulus: x7 has cnt=1; same cycle issue a write to x7 and retire x7.
  - Response: cnt[7] stays 1, busy_o[7]=1, inflight_o unchanged.
- x0 and flush:
  - Stimulus: issue a write to x0.
  - Response: busy_o and inflight_o unchanged.
  - Stimulus: dec_valid_i=1, exm_ready_i=1, flush_i=1, no hazard.
  - Response: stall_o=1, issue_o=0.
- Error:
  - Stimulus: retire x9 with cnt[9]=0.
  - Response: error_o=1 next cycle and stays 1; other counters unchanged.
